// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enabled true dual-port RAM and its per-port read pipeline.
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dpram_port_pipe.sv
// Per-port read path: same-port write-first merge followed by a 1- or 2-stage
// read-data/valid pipeline.
module dpram_port_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = RDW_READ_FIRST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH-1:0]   mem_word,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid
);

    localparam int NUM_BYTES = bytes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] read_word;
    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;

    // NOTE: the default assignment before the loop keeps this block purely combinational (no latch).
    always_comb begin
        merged = mem_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (we[i]) merged[8*i +: 8] = data_in[8*i +: 8];
        end
    end

    assign read_word = (RDW_MODE == RDW_WRITE_FIRST) ? merged : mem_word;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= accept;
                if (accept) s1_data <= read_word;
            end
        end

        assign stage_valid = s1_valid;
        assign stage_data  = s1_data;
    end else begin : g_lat1
        assign stage_valid = accept;
        assign stage_data  = read_word;
    end

    // Output register holds its last data when no access reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            valid <= stage_valid;
            if (stage_valid) data_out <= stage_data;
        end
    end

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with byte enables, write-write collision flag
// and an optional zero-fill sweep after reset.
module dual_port_ram_be
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = RDW_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_a,
    input  logic [DATA_WIDTH/8-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   data_in_a,
    output logic [DATA_WIDTH-1:0]   data_out_a,
    output logic                    valid_a,
    input  logic                    en_b,
    input  logic [DATA_WIDTH/8-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   data_in_b,
    output logic [DATA_WIDTH-1:0]   data_out_b,
    output logic                    valid_b,
    output logic                    busy,
    output logic                    collision
);

    localparam int                    NUM_BYTES = bytes_of(DATA_WIDTH);
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  acc_a;
    logic                  acc_b;
    logic                  collide;

    assign acc_a   = en_a && (state == RUN) && !rst;
    assign acc_b   = en_b && (state == RUN) && !rst;
    assign collide = acc_a && acc_b && (addr_a == addr_b) && ((we_a & we_b) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            busy      <= (CLEAR_ON_RESET != 0);
            cnt       <= '0;
            collision <= 1'b0;
        end else begin
            collision <= collide;
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

    // NOTE: the array has no reset branch; clearing is the sweep's job, which keeps it a plain RAM.
    // B is written first so that A's enabled bytes override it on a shared address.
    always_ff @(posedge clk) begin
        if (state == CLEAR && !rst) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (acc_b && we_b[i]) mem[addr_b][8*i +: 8] <= data_in_b[8*i +: 8];
                if (acc_a && we_a[i]) mem[addr_a][8*i +: 8] <= data_in_a[8*i +: 8];
            end
        end
    end

    dpram_port_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY),
        .RDW_MODE    (RDW_MODE)
    ) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .accept  (acc_a),
        .we      (we_a),
        .data_in (data_in_a),
        .mem_word(mem[addr_a]),
        .data_out(data_out_a),
        .valid   (valid_a)
    );

    dpram_port_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY),
        .RDW_MODE    (RDW_MODE)
    ) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .accept  (acc_b),
        .we      (we_b),
        .data_in (data_in_b),
        .mem_word(mem[addr_b]),
        .data_out(data_out_b),
        .valid   (valid_b)
    );

endmodule
